// File: rtl/systolic_row_feeder_pkg.sv
// Shared types and helpers for the systolic row feeder.
// Holds the FSM state encoding, the default word width and a constant clog2.
package systolic_row_feeder_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_row_feeder_skew_lane.sv
// One lane of the skew: a (DELAY+1)-deep data/valid shift register with enable.
// The word entering on d appears on q after DELAY+1 enabled cycles.
module skew_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int DELAY      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  v_in,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  v_out
);

    logic [DATA_WIDTH-1:0] data_sr [DELAY+1];
    logic [DELAY:0]        valid_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= DELAY; k++) begin
                data_sr[k] <= '0;
            end
            valid_sr <= '0;
        end else if (en) begin
            data_sr[0]  <= d;
            valid_sr[0] <= v_in;
            for (int k = 1; k <= DELAY; k++) begin
                data_sr[k]  <= data_sr[k-1];
                valid_sr[k] <= valid_sr[k-1];
            end
        end
    end

    assign q     = data_sr[DELAY];
    assign v_out = valid_sr[DELAY];

endmodule

// File: rtl/systolic_row_feeder.sv
// Feeds row vectors into the systolic array as a skewed wavefront (lane i delayed by i advances).
// After the last vector of a block, LANES-1 bubbles drain the skew before new input is taken.
module systolic_row_feeder
    import systolic_row_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LANES      = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] in_vec,
    input  logic                        in_stb,
    input  logic                        in_last,
    output logic                        in_ack,
    input  logic                        arr_ack,
    output logic [LANES*DATA_WIDTH-1:0] lane_data,
    output logic [LANES-1:0]            lane_stb,
    output logic                        out_last,
    output logic                        busy,
    output logic [CNT_W-1:0]            vec_cnt,
    output logic [1:0]                  state
);

    localparam int              FC_W    = clog2(LANES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(LANES - 2);

    // Handshake: a vector moves when in_stb && in_ack; the array takes one
    // wavefront step whenever arr_ack is high and the feeder advances.
    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            bubble;
    logic            adv;
    logic            flush_done;
    logic [FC_W-1:0] flush_cnt;
    logic [LANES-1:0] last_sr;

    assign accept     = in_stb && in_ack;
    assign bubble     = (state_q == ST_FLUSH) && arr_ack;
    assign adv        = accept || bubble;
    assign flush_done = bubble && (flush_cnt == FC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = in_last ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept && in_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ack = rst && arr_ack && (state_q != ST_FLUSH);
        busy   = (state_q != ST_IDLE);
        state  = state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= '0;
        end else if (bubble) begin
            flush_cnt <= flush_done ? '0 : flush_cnt + 1'b1;
        end
    end

    // Last tag travels with the final lane only, so it lines up with its element there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_sr <= '0;
        end else if (adv) begin
            last_sr <= {last_sr[LANES-2:0], accept && in_last};
        end
    end

    assign out_last = last_sr[LANES-1] && lane_stb[LANES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_cnt <= '0;
        end else if (accept) begin
            vec_cnt <= (state_q == ST_IDLE) ? CNT_W'(1) : vec_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DELAY      (i)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .d     (accept ? in_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0),
            .v_in  (accept),
            .q     (lane_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .v_out (lane_stb[i])
        );
    end

endmodule
